uartm_rx: RTL

UART-master serial receiver, the inbound counterpart of the UART-master transmitter. It deserializes frames arriving on RX (start bit, LSB-first 8/16/32-bit data, optional parity, stop bit) using the shared uartm_baud/uartm_ctl programming. It presents each word in a one-entry holding register with a valid/ready handshake toward the UART-master command/AHB logic, and flags parity, framing and overrun errors.

---
 rtl/uartm_rx_pkg.sv | 36 +++
 rtl/uartm_rx_sync.sv | 41 ++++
 rtl/uartm_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/uartm_rx_pkg.sv
// Shared UART-master definitions: receiver FSM states, data-width decode
// and uartm_ctl bit positions (the transmitter reads the same control word).
package uartm_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // uartm_ctl field positions
    localparam int unsigned CTL_WIDTH_LO = 0;
    localparam int unsigned CTL_WIDTH_HI = 1;
    localparam int unsigned CTL_PAR_EN   = 2;
    localparam int unsigned CTL_PAR_EVEN = 3;

    // uartm_ctl[1:0] width codes; the fourth code falls back to 8 bits
    localparam logic [1:0] WIDTH_CODE_8  = 2'b00;
    localparam logic [1:0] WIDTH_CODE_16 = 2'b01;
    localparam logic [1:0] WIDTH_CODE_32 = 2'b10;

    localparam logic [5:0] NBITS_8  = 6'd8;
    localparam logic [5:0] NBITS_16 = 6'd16;
    localparam logic [5:0] NBITS_32 = 6'd32;

    function automatic logic [5:0] width_bits(input logic [1:0] code);
        case (code)
            WIDTH_CODE_16: return NBITS_16;
            WIDTH_CODE_32: return NBITS_32;
            default:       return NBITS_8;
        endcase
    endfunction

endpackage

// File: rtl/uartm_rx_sync.sv
// RX metastability synchronizer. With UARTM_RX_MAJORITY_EN defined it also
// provides the 2-of-3 vote over the current and two previous synchronized
// samples, so a decision taken at s+1 covers s-1, s and s+1.
module uartm_rx_sync #(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic hclk,
    input  logic hreset,
    input  logic rx,
    output logic rxs
`ifdef UARTM_RX_MAJORITY_EN
    ,
    output logic rxs_maj
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift chain; resets to the idle-high line level so no false start is seen.
    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (hreset) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef UARTM_RX_MAJORITY_EN
    logic [1:0] hist_q;

    // Two-deep history of rxs feeding the vote window.
    always_ff @(posedge hclk) begin
        if (hreset) hist_q <= 2'b11;
        else        hist_q <= {hist_q[0], rxs};
    end

    assign rxs_maj = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`endif

endmodule

// File: rtl/uartm_rx.sv
// UART-master serial receiver: start bit, LSB-first 8/16/32-bit data,
// optional parity, stop bit; one-entry holding register with valid/ready.
// Optional build macro UARTM_RX_MAJORITY_EN enables 3-sample majority voting.
module uartm_rx
    import uartm_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        RX,
    input  logic [31:0] uartm_baud,
    input  logic [31:0] uartm_ctl,
    output logic [31:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        rx_ovr,
    output logic        rx_busy
);

    rx_state_e   state_q, state_d;
    logic [31:0] cnt_q, baud_q, data_q, target;
    logic [5:0]  nbits_q, bit_cnt_q;
    logic        par_en_q, par_even_q, perr_q;
    logic        rxs, sample_tick, decide, bit_val, last_bit, start_direct;
    logic        unused_ctl;

    // Only the low control bits are defined; the rest are ignored.
    assign unused_ctl = ^uartm_ctl[31:4];

`ifdef UARTM_RX_MAJORITY_EN
    logic rxs_maj, maj_on, pend_q;

    uartm_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .hclk    (hclk),
        .hreset  (hreset),
        .rx      (RX),
        .rxs     (rxs),
        .rxs_maj (rxs_maj)
    );

    // Voting needs a full window inside one bit, so short periods fall back to s.
    assign maj_on  = (baud_q >= 32'd2);
    assign decide  = maj_on ? pend_q : sample_tick;
    assign bit_val = maj_on ? rxs_maj : rxs;

    // Delays the decision one cycle past the nominal sample point.
    always_ff @(posedge hclk) begin
        if (hreset || state_q == ST_IDLE) pend_q <= 1'b0;
        else                              pend_q <= maj_on && sample_tick;
    end
`else
    uartm_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .hclk   (hclk),
        .hreset (hreset),
        .rx     (RX),
        .rxs    (rxs)
    );

    assign decide  = sample_tick;
    assign bit_val = rxs;
`endif

    // With a zero half-bit offset the detect cycle itself is the start check.
    assign start_direct = (uartm_baud[31:1] == 31'd0);
    assign target       = (state_q == ST_START) ? (baud_q >> 1) : baud_q;
    assign sample_tick  = (state_q != ST_IDLE) && (cnt_q == target);
    assign last_bit     = (bit_cnt_q == nbits_q - 6'd1);
    assign rx_busy      = (state_q != ST_IDLE);

    // FSM state register.
    always_ff @(posedge hclk) begin
        if (hreset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state decode.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!rxs) state_d = start_direct ? ST_DATA : ST_START;
            ST_START:  if (decide) state_d = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (decide && last_bit) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (decide) state_d = ST_STOP;
            ST_STOP:   if (decide) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bit timing, frame configuration latch and deserialization.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            cnt_q      <= '0;
            baud_q     <= '0;
            nbits_q    <= NBITS_8;
            par_en_q   <= 1'b0;
            par_even_q <= 1'b0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            perr_q     <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            // Counter value tracks cycles since the start edge was seen.
            cnt_q <= start_direct ? 32'd0 : 32'd1;
            if (!rxs) begin
                baud_q     <= uartm_baud;
                nbits_q    <= width_bits(uartm_ctl[CTL_WIDTH_HI:CTL_WIDTH_LO]);
                par_en_q   <= uartm_ctl[CTL_PAR_EN];
                par_even_q <= uartm_ctl[CTL_PAR_EVEN];
                bit_cnt_q  <= '0;
                data_q     <= '0;
                perr_q     <= 1'b0;
            end
        end else begin
            cnt_q <= sample_tick ? 32'd0 : cnt_q + 32'd1;
            if (decide && state_q == ST_DATA) begin
                data_q[bit_cnt_q[4:0]] <= bit_val;
                bit_cnt_q              <= bit_cnt_q + 6'd1;
            end
            if (decide && state_q == ST_PARITY)
                perr_q <= bit_val != (par_even_q ? ^data_q : ~^data_q);
        end
    end

    // Holding register, handshake and overrun reporting.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
            rx_ovr   <= 1'b0;
        end else begin
            rx_ovr <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (decide && state_q == ST_STOP) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= data_q;
                    rx_perr  <= perr_q;
                    rx_ferr  <= ~bit_val;
                    rx_valid <= 1'b1;
                end else begin
                    rx_ovr <= 1'b1;
                end
            end
        end
    end

endmodule
